// File: rtl/rr_arbiter_if.sv
// Requester/resource side of the round-robin arbiter: request vector, grant outputs
// and the already-muxed beat handshake from the shared resource.
interface rr_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned IdxW = $clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] gnt;
   logic [IdxW-1:0]  gnt_idx;
   logic             gnt_vld;
   logic             bus_vld;
   logic             bus_rdy;
   logic             bus_lst;
   logic             tmo_err;

   // Requesters and resource drive requests and beats, observe the grant.
   modport master (
      output req, bus_vld, bus_rdy, bus_lst,
      input  gnt, gnt_idx, gnt_vld, tmo_err
   );

   // The arbiter itself.
   modport slave (
      input  req, bus_vld, bus_rdy, bus_lst,
      output gnt, gnt_idx, gnt_vld, tmo_err
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one shared resource. A grant is held for a whole
// transaction (until the last accepted beat) or until the stall watchdog fires.

// Lowest-set-bit encoder, organised as SPLIT groups: first non-empty group wins,
// then the lowest set bit inside that group.
module priority_encoder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SPLIT = 2
) (
   input  logic [WIDTH-1:0]         req_i,
   output logic [$clog2(WIDTH)-1:0] idx_o,
   output logic                     vld_o
);
   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam int unsigned GrpW = (WIDTH + SPLIT - 1) / SPLIT;
   localparam int unsigned PadW = GrpW * SPLIT;

   logic [PadW-1:0]  req_pad;
   logic [SPLIT-1:0] grp_any;

   // Pad to whole groups and flag every group holding a request.
   always_comb begin
      req_pad = '0;
      req_pad[WIDTH-1:0] = req_i;
      grp_any = '0;
      for (int unsigned g = 0; g < SPLIT; g++) begin
         grp_any[g] = |req_pad[g*GrpW +: GrpW];
      end
   end

   // Pick the lowest non-empty group; the descending scan leaves its lowest bit.
   always_comb begin : p_sel
      logic found;
      found = 1'b0;
      idx_o = '0;
      for (int unsigned g = 0; g < SPLIT; g++) begin
         if (!found && grp_any[g]) begin
            found = 1'b1;
            for (int b = int'(GrpW) - 1; b >= 0; b--) begin
               if (req_pad[g*GrpW + b]) begin
                  idx_o = IdxW'(g*GrpW + b);
               end
            end
         end
      end
   end

   assign vld_o = |req_i;
endmodule

module rr_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SPLIT   = 2,
   parameter int unsigned TIMEOUT = 256
) (
   input logic         clk,
   input logic         rst,
   rr_arbiter_if.slave arb_io
);
   localparam int unsigned IdxW = $clog2(WIDTH);
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [IdxW-1:0]  gnt_idx_q, gnt_idx_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   logic             hs, rel_lst, expire, release_ev;
   logic [IdxW-1:0]  ptr_arb, idx_m, idx_u, winner;
   logic [WIDTH-1:0] mreq;
   logic             vld_m, vld_u;

   assign hs         = arb_io.bus_vld & arb_io.bus_rdy;
   assign rel_lst    = (state_q == StBusy) & hs & arb_io.bus_lst;
   // A last-beat handshake on the expiry cycle is a normal release: expire needs !hs.
   assign expire     = (TIMEOUT != 0) && (state_q == StBusy) && !hs && (cnt_q == CntMax);
   assign release_ev = rel_lst | expire;

   // Mask requests below the pointer; on release the rotated pointer is used at once.
   always_comb begin
      ptr_arb = ptr_q;
      if (release_ev) begin
         ptr_arb = (gnt_idx_q == IdxW'(WIDTH - 1)) ? '0 : gnt_idx_q + 1'b1;
      end
      mreq = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         mreq[i] = arb_io.req[i] & (IdxW'(i) >= ptr_arb);
      end
   end

   priority_encoder #(
      .WIDTH (WIDTH),
      .SPLIT (SPLIT)
   ) u_pe_masked (
      .req_i (mreq),
      .idx_o (idx_m),
      .vld_o (vld_m)
   );

   priority_encoder #(
      .WIDTH (WIDTH),
      .SPLIT (SPLIT)
   ) u_pe_plain (
      .req_i (arb_io.req),
      .idx_o (idx_u),
      .vld_o (vld_u)
   );

   assign winner = vld_m ? idx_m : idx_u;

   // Next-state: grant on any request when idle; hold until release when busy.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      gnt_vld_d = gnt_vld_q;
      cnt_d     = cnt_q;
      tmo_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (vld_u) begin
               state_d   = StBusy;
               gnt_d     = WIDTH'(1) << winner;
               gnt_idx_d = winner;
               gnt_vld_d = 1'b1;
               cnt_d     = '0;
            end
         end
         StBusy: begin
            if (release_ev) begin
               ptr_d = ptr_arb;
               tmo_d = expire;
               cnt_d = '0;
               if (vld_u) begin
                  gnt_d     = WIDTH'(1) << winner;
                  gnt_idx_d = winner;
               end else begin
                  state_d   = StIdle;
                  gnt_d     = '0;
                  gnt_vld_d = 1'b0;
               end
            end else if (hs) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
         gnt_vld_q <= 1'b0;
         cnt_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_vld_q <= gnt_vld_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign arb_io.gnt     = gnt_q;
   assign arb_io.gnt_idx = gnt_idx_q;
   assign arb_io.gnt_vld = gnt_vld_q;
   assign arb_io.tmo_err = tmo_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios with literal expectations plus a
// round-robin reference model compared on every negative clock edge.
module tb_rr_arbiter;
   localparam int W   = 8;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference model state.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_stall = 0;
   bit   m_tmo   = 1'b0;

   rr_arbiter_if #(.WIDTH(W)) arb_if ();

   rr_arbiter #(
      .WIDTH   (W),
      .SPLIT   (2),
      .TIMEOUT (TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_io (arb_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // First requester at or after p in circular order.
   function automatic int rr_pick(input logic [W-1:0] r, input int p);
      for (int k = 0; k < W; k++) begin
         if (r[(p + k) % W]) return (p + k) % W;
      end
      return -1;
   endfunction

   always @(posedge clk) begin : p_model
      int own, ptr, stall;
      bit tmo, rel, hs;
      own = m_owner; ptr = m_ptr; stall = m_stall; tmo = 1'b0; rel = 1'b0;
      hs = arb_if.bus_vld && arb_if.bus_rdy;
      if (rst) begin
         own = -1; ptr = 0; stall = 0;
      end else if (own < 0) begin
         if (arb_if.req != 0) begin
            own = rr_pick(arb_if.req, ptr);
            stall = 0;
         end
      end else begin
         if (hs && arb_if.bus_lst) rel = 1'b1;
         else if (!hs && stall == TMO - 1) begin
            rel = 1'b1;
            tmo = 1'b1;
         end else if (hs) stall = 0;
         else stall = stall + 1;
         if (rel) begin
            ptr = (own + 1) % W;
            stall = 0;
            own = (arb_if.req != 0) ? rr_pick(arb_if.req, ptr) : -1;
         end
      end
      m_owner <= own;
      m_ptr   <= ptr;
      m_stall <= stall;
      m_tmo   <= tmo;
   end

   always @(negedge clk) begin : p_cmp
      logic [W-1:0] eg;
      if (chk_en) begin
         eg = (m_owner >= 0) ? (W'(1) << m_owner) : '0;
         chk("model_gnt", 32'(arb_if.gnt), 32'(eg));
         chk("model_vld", 32'(arb_if.gnt_vld), 32'(m_owner >= 0));
         if (m_owner >= 0) chk("model_idx", 32'(arb_if.gnt_idx), 32'(m_owner));
         chk("model_tmo", 32'(arb_if.tmo_err), 32'(m_tmo));
         chk("invariant", 32'({$onehot0(arb_if.gnt), arb_if.gnt_vld == |arb_if.gnt}), 32'h3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic r, input logic l);
      arb_if.bus_vld = v;
      arb_if.bus_rdy = r;
      arb_if.bus_lst = l;
   endtask

   task automatic expect_gnt(input string name, input logic [W-1:0] g, input int idx);
      chk({name, "_gnt"}, 32'(arb_if.gnt), 32'(g));
      chk({name, "_vld"}, 32'(arb_if.gnt_vld), 32'(g != 0));
      if (g != 0) chk({name, "_idx"}, 32'(arb_if.gnt_idx), 32'(idx));
   endtask

   initial begin
      arb_if.req = '0;
      beat(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      chk("rst_gnt", 32'(arb_if.gnt), 32'h0);
      chk("rst_idx", 32'(arb_if.gnt_idx), 32'h0);
      chk("rst_vld", 32'(arb_if.gnt_vld), 32'h0);
      chk("rst_tmo", 32'(arb_if.tmo_err), 32'h0);
      rst = 1'b0;

      // Single requester, 1-cycle latency, release on lst beat, ptr -> 4.
      arb_if.req = 8'h08;
      tick();
      expect_gnt("single", 8'h08, 3);
      tick();
      tick();
      arb_if.req = 8'h00;
      beat(1'b1, 1'b1, 1'b1);
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("single_rel", 8'h00, 0);
      chk("single_mptr", 32'(m_ptr), 32'd4);
      arb_if.req = 8'h11;
      tick();
      expect_gnt("ptr4", 8'h10, 4);
      arb_if.req = 8'h00;
      beat(1'b1, 1'b1, 1'b1);
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("ptr4_rel", 8'h00, 0);

      // Fairness: all requesting, single-beat transactions, no bubbles.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      arb_if.req = 8'hFF;
      tick();
      expect_gnt("fair0", 8'h01, 0);
      beat(1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         logic [W-1:0] e;
         e = W'(1) << (k % W);
         tick();
         expect_gnt("fair", e, k % W);
      end
      arb_if.req = 8'h00;
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("fair_end", 8'h00, 0);

      // Pointer wrap: reach ptr=6, then req=0x05 -> 0, then -> 2.
      arb_if.req = 8'h20;
      tick();
      expect_gnt("wrap_pre", 8'h20, 5);
      arb_if.req = 8'h00;
      beat(1'b1, 1'b1, 1'b1);
      tick();
      beat(1'b0, 1'b0, 1'b0);
      chk("wrap_mptr", 32'(m_ptr), 32'd6);
      arb_if.req = 8'h05;
      tick();
      expect_gnt("wrap0", 8'h01, 0);
      beat(1'b1, 1'b1, 1'b1);
      tick();
      expect_gnt("wrap2", 8'h04, 2);
      arb_if.req = 8'h00;
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("wrap_end", 8'h00, 0);

      // Hold/stall: owner drops req, resource stalls, late requester waits.
      arb_if.req = 8'h02;
      tick();
      expect_gnt("hold", 8'h02, 1);
      arb_if.req = 8'h00;
      beat(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) arb_if.req = 8'h10;
         tick();
         expect_gnt("hold_stall", 8'h02, 1);
      end
      beat(1'b1, 1'b1, 1'b1);
      tick();
      expect_gnt("hold_next", 8'h10, 4);
      arb_if.req = 8'h00;
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("hold_end", 8'h00, 0);

      // Watchdog expiry 16 cycles after grant, then lst on the expiry cycle.
      arb_if.req = 8'h04;
      tick();
      expect_gnt("wd", 8'h04, 2);
      arb_if.req = 8'h44;
      beat(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         tick();
         expect_gnt("wd_stall", 8'h04, 2);
         chk("wd_stall_tmo", 32'(arb_if.tmo_err), 32'h0);
      end
      tick();
      expect_gnt("wd_fire", 8'h40, 6);
      chk("wd_fire_tmo", 32'(arb_if.tmo_err), 32'h1);
      tick();
      chk("wd_pulse_end", 32'(arb_if.tmo_err), 32'h0);
      for (int i = 0; i < 14; i++) begin
         tick();
         expect_gnt("wd2_stall", 8'h40, 6);
      end
      beat(1'b1, 1'b1, 1'b1);
      tick();
      expect_gnt("wd2_lst", 8'h04, 2);
      chk("wd2_tmo", 32'(arb_if.tmo_err), 32'h0);
      arb_if.req = 8'h00;
      tick();
      beat(1'b0, 1'b0, 1'b0);
      expect_gnt("wd_end", 8'h00, 0);

      // Reset mid-transaction.
      arb_if.req = 8'h20;
      tick();
      expect_gnt("rmid", 8'h20, 5);
      rst = 1'b1;
      tick();
      chk("rmid_gnt", 32'(arb_if.gnt), 32'h0);
      chk("rmid_idx", 32'(arb_if.gnt_idx), 32'h0);
      chk("rmid_vld", 32'(arb_if.gnt_vld), 32'h0);
      chk("rmid_tmo", 32'(arb_if.tmo_err), 32'h0);
      chk("rmid_mptr", 32'(m_ptr), 32'd0);
      rst = 1'b0;
      arb_if.req = 8'h21;
      tick();
      expect_gnt("rmid_after", 8'h01, 0);
      arb_if.req = 8'h00;
      beat(1'b1, 1'b1, 1'b1);
      tick();
      beat(1'b0, 1'b0, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (bus/port) between WIDTH requesters.
- Arbitration uses two priority_encoder instances:
  - one on the requests masked at or above the round-robin pointer;
  - one on the unmasked requests.
- A grant is held for a whole transaction, until the resource signals the last accepted beat.
- A watchdog releases a grant that stalls too long.
- Sits between requester ports and the shared resource mux; gnt_idx drives the mux select.

Parameters:
- WIDTH, 8, number of requesters; WIDTH >= 2.
- SPLIT, 2, split factor passed to both internal priority_encoder instances.
- TIMEOUT, 256, max consecutive granted cycles without a handshake (bus_vld && bus_rdy) before forced release; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  WIDTH  request per requester, level-sensitive.
- gnt  output  WIDTH  one-hot grant, registered.
- gnt_idx  output  $clog2(WIDTH)  index of the granted requester, registered.
- gnt_vld  output  1  a grant is active, registered.
- bus_vld  input  1  granted requester presents a beat (already muxed by gnt_idx).
- bus_rdy  input  1  resource accepts a beat.
- bus_lst  input  1  beat is the last of the transaction.
- tmo_err  output  1  one-cycle pulse on watchdog release, registered.

Behaviour:
- Reset: gnt=0, gnt_idx=0, gnt_vld=0, tmo_err=0, ptr=0, watchdog counter=0, state=IDLE.
- Reset mid-transaction drops the grant in the next cycle with no release handshake.
- Arbitration (combinational):
  - mreq = req & ~((1<<ptr)-1).
  - Winner = lowest set index of mreq if mreq!=0, else lowest set index of req.
  - Any = |req.
- States: IDLE, BUSY.
- IDLE:
  - If Any: next cycle gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, state=BUSY, counter=0.
  - Latency from req rising to gnt = 1 cycle.
- BUSY:
  - Grant is held unchanged regardless of req changes, including the owner deasserting req.
  - Release event = (bus_vld && bus_rdy && bus_lst) or watchdog expiry.
  - On release: ptr <= (gnt_idx+1) mod WIDTH, wrapping from WIDTH-1 to 0.
  - Next grant is computed with the updated pointer, i.e. the mask uses gnt_idx+1, not the old ptr.
  - If another request is pending at release, the new grant appears the next cycle (no bubble) and state stays BUSY; otherwise gnt=0, gnt_vld=0, state=IDLE.
  - The releasing requester's own req is a valid candidate; it wins only if no other request lies in round-robin order before it.
- Watchdog:
  - Counter increments each BUSY cycle without (bus_vld && bus_rdy).
  - Counter clears on any handshake and on a new grant.
  - When counter == TIMEOUT-1 and no handshake in that cycle: release and tmo_err=1 for exactly one cycle.
  - Counter width = $clog2(TIMEOUT+1).
- Simultaneous handshake-with-last and watchdog expiry: treated as a normal release, tmo_err=0.
- Outputs go only from flops; no combinational path from req to gnt.
- Invariant: gnt is one-hot or zero, and gnt_vld == |gnt.

Test Plan:
- Single requester: WIDTH=8, req=0x08 at cycle 0 → gnt=0x08, gnt_idx=3, gnt_vld=1 at cycle 1. Beat with bus_lst accepted at cycle 4 → gnt=0 at cycle 5, ptr=4.
- Fairness: req=0xFF held, each grant completes with a single-beat lst transfer → grant order 0,1,2,...,7,0; no idle cycles between grants.
- Pointer wrap: ptr=6, req=0x05 → grant idx 0. After release, with req still 0x05 → grant idx 2.
- Hold/stall: grant to idx 1, owner drops req, bus_rdy=0 for 10 cycles, req=0x10 arrives → gnt stays 0x02 until the lst handshake, then gnt=0x10.
- Watchdog: TIMEOUT=16, grant idx 2, bus_rdy=0 → release 16 cycles after the grant, tmo_err pulses once, next pending requester granted. Repeat with lst handshake on the expiry cycle → no tmo_err.
- Reset mid-op: assert rst during BUSY with gnt=0x20 → next cycle all outputs 0, ptr=0. After rst drops with req=0x21 → grant idx 0.
